// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared lane maps and sizing helpers for the pi pipeline
// Purpose: lane indexing, forward/inverse pi lane maps, beat and counter sizing.
// Ports: none (package).
package keccak_pkg;

  localparam int unsigned LANES = 25;

  // Lane l = 5x+y moves to lane PI_FWD[l] under forward pi, i.e. to (y, (2x+3y)%5).
  // Gathering with this map (out[l] = in[PI_FWD[l]]) is the inverse pi.
  localparam int unsigned PI_FWD [LANES] = '{
     0,  8, 11, 19, 22,
     2,  5, 13, 16, 24,
     4,  7, 10, 18, 21,
     1,  9, 12, 15, 23,
     3,  6, 14, 17, 20
  };

  // PI_INV[d] is the source lane that forward pi moves into lane d.
  // Gathering with this map (out[d] = in[PI_INV[d]]) is the forward pi.
  localparam int unsigned PI_INV [LANES] = '{
     0, 15,  5, 20, 10,
     6, 21, 11,  1, 16,
    12,  2, 17,  7, 22,
    18,  8, 23, 13,  3,
    24, 14,  4, 19,  9
  };

  // Bit offset of lane (x,y) inside one share; slices z ascend within the field.
  function automatic int unsigned idx(input int unsigned x, input int unsigned y,
                                      input int unsigned sp);
    return (5 * x + y) * sp;
  endfunction

  function automatic int unsigned beats_per_state(input int unsigned w, input int unsigned sp);
    return w / sp;
  endfunction

  // A single-beat state still needs a 1-bit counter so the port widths stay legal.
  function automatic int unsigned cnt_width(input int unsigned w, input int unsigned sp);
    return ((w / sp) <= 1) ? 1 : $clog2(w / sp);
  endfunction

endpackage

// File: rtl/keccak_pi_share.sv
// rtl/keccak_pi_share.sv - combinational pi / inverse pi on one share
// Purpose: permutes the 25 lanes of SP slices of a single share.
// Ports:
//   inv_i    - 1 selects inverse pi, 0 selects forward pi
//   slices_i - 25*SP input bits, lane (x,y) at idx(x,y,SP)
//   slices_o - 25*SP permuted bits, same layout
module keccak_pi_share #(
  parameter int unsigned SP = 1
) (
  input  logic              inv_i,
  input  logic [25*SP-1:0]  slices_i,
  output logic [25*SP-1:0]  slices_o
);
  import keccak_pkg::*;

  logic [25*SP-1:0] fwd_w;
  logic [25*SP-1:0] inv_w;

  // Both directions are pure wiring; each output lane gathers a whole SP-wide field.
  for (genvar l = 0; l < 25; l++) begin : g_lane
    localparam int unsigned DST_X = l / 5;
    localparam int unsigned DST_Y = l % 5;
    localparam int unsigned FSRC  = PI_INV[l];
    localparam int unsigned ISRC  = PI_FWD[l];

    assign fwd_w[idx(DST_X, DST_Y, SP) +: SP] = slices_i[idx(FSRC / 5, FSRC % 5, SP) +: SP];
    assign inv_w[idx(DST_X, DST_Y, SP) +: SP] = slices_i[idx(ISRC / 5, ISRC % 5, SP) +: SP];
  end

  assign slices_o = inv_i ? inv_w : fwd_w;

endmodule

// File: rtl/keccak_pi_pipe.sv
// rtl/keccak_pi_pipe.sv - masked, handshaked pi step with 2-entry skid buffer
// Purpose: applies pi or inverse pi (chosen on beat 0 of each state) to every
//   share, buffers results in a 2-entry FIFO and tags first/last beats.
// Ports:
//   ClkxCI, RstxRBI        - clock, asynchronous active-low reset
//   ClearxSI               - synchronous flush of buffer, counters and mode
//   SlicesxDI/ValidxSI/ReadyxSO/InvxSI - input beat, share s at [s*25*SP +: 25*SP]
//   SlicesxDO/ValidxSO/ReadyxSI        - permuted output beat
//   FirstxSO, LastxSO      - output beat is beat 0 / beat W/SP-1 of its state
module keccak_pi_pipe #(
  parameter int unsigned SLICES_PARALLEL = 1,
  parameter int unsigned SHARES          = 2,
  parameter int unsigned LANE_WIDTH      = 64
) (
  input  logic                                 ClkxCI,
  input  logic                                 RstxRBI,
  input  logic                                 ClearxSI,
  input  logic [25*SLICES_PARALLEL*SHARES-1:0] SlicesxDI,
  input  logic                                 ValidxSI,
  output logic                                 ReadyxSO,
  input  logic                                 InvxSI,
  output logic [25*SLICES_PARALLEL*SHARES-1:0] SlicesxDO,
  output logic                                 ValidxSO,
  input  logic                                 ReadyxSI,
  output logic                                 FirstxSO,
  output logic                                 LastxSO
);
  import keccak_pkg::*;

  localparam int unsigned SP      = SLICES_PARALLEL;
  localparam int unsigned SHARE_W = 25 * SP;
  localparam int unsigned DATA_W  = SHARE_W * SHARES;
  localparam int unsigned BEATS   = beats_per_state(LANE_WIDTH, SP);
  localparam int unsigned CW      = cnt_width(LANE_WIDTH, SP);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  if (((LANE_WIDTH % SP) != 0) || (SHARES < 1)) begin : g_param_check
    $fatal(1, "keccak_pi_pipe: LANE_WIDTH must be a multiple of SLICES_PARALLEL and SHARES must be >= 1");
  end

  logic [DATA_W-1:0] perm_w;
  logic              use_inv_w;
  logic              accept_w;
  logic              deliver_w;

  logic [1:0]        count_q, count_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic [CW-1:0]     icnt_q, icnt_d;
  logic [CW-1:0]     ocnt_q, ocnt_d;
  logic              mode_q, mode_d;

  // Beat 0 takes the live mode input; later beats reuse the mode latched on beat 0.
  assign use_inv_w = (icnt_q == '0) ? InvxSI : mode_q;

  for (genvar s = 0; s < SHARES; s++) begin : g_share
    keccak_pi_share #(.SP(SP)) u_share (
      .inv_i    (use_inv_w),
      .slices_i (SlicesxDI[s*SHARE_W +: SHARE_W]),
      .slices_o (perm_w[s*SHARE_W +: SHARE_W])
    );
  end

  assign accept_w  = ValidxSI & ready_q;
  assign deliver_w = ValidxSO & ReadyxSI;

  assign ReadyxSO  = ready_q;
  assign ValidxSO  = (count_q != 2'd0);
  assign SlicesxDO = buf0_q;
  assign FirstxSO  = ValidxSO & (ocnt_q == '0);
  assign LastxSO   = ValidxSO & (ocnt_q == LAST_BEAT);

  always_comb begin
    count_d = count_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    icnt_d  = icnt_q;
    ocnt_d  = ocnt_q;
    mode_d  = mode_q;

    if (ClearxSI) begin
      count_d = 2'd0;
      icnt_d  = '0;
      ocnt_d  = '0;
      mode_d  = 1'b0;
    end else begin
      if (accept_w) begin
        icnt_d = (icnt_q == LAST_BEAT) ? '0 : icnt_q + 1'b1;
        if (icnt_q == '0) begin
          mode_d = InvxSI;
        end
      end
      if (deliver_w) begin
        ocnt_d = (ocnt_q == LAST_BEAT) ? '0 : ocnt_q + 1'b1;
      end

      // buf0 is always the head, so the output is a plain register.
      case (count_q)
        2'd0: begin
          if (accept_w) begin
            buf0_d  = perm_w;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (accept_w && deliver_w) begin
            buf0_d = perm_w;
          end else if (accept_w) begin
            buf1_d  = perm_w;
            count_d = 2'd2;
          end else if (deliver_w) begin
            count_d = 2'd0;
          end
        end
        default: begin
          // Full: ready is low, so only a delivery can happen.
          if (deliver_w) begin
            buf0_d  = buf1_q;
            count_d = 2'd1;
          end
        end
      endcase
    end

    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge ClkxCI or negedge RstxRBI) begin
    if (!RstxRBI) begin
      count_q <= 2'd0;
      ready_q <= 1'b1;
      buf0_q  <= '0;
      buf1_q  <= '0;
      icnt_q  <= '0;
      ocnt_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= ready_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      icnt_q  <= icnt_d;
      ocnt_q  <= ocnt_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_keccak_pi_pipe.sv
// tb/tb_keccak_pi_pipe.sv - self-checking bench for keccak_pi_pipe
module tb_keccak_pi_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: SP=1, 2 shares, W=64
  logic        a_clr = 1'b0, a_vin = 1'b0, a_inv = 1'b0, a_rdy_i = 1'b0;
  logic        a_rdy_o, a_vout, a_first, a_last;
  logic [49:0] a_din = '0;
  logic [49:0] a_dout;
  // B: SP=4, 2 shares, W=64 (16 beats per state)
  logic         b_clr = 1'b0, b_vin = 1'b0, b_inv = 1'b0, b_rdy_i = 1'b0;
  logic         b_rdy_o, b_vout, b_first, b_last;
  logic [199:0] b_din = '0;
  logic [199:0] b_dout;
  // C: SP=2, 1 share, W=2 (one beat per state)
  logic        c_clr = 1'b0, c_vin = 1'b0, c_inv = 1'b0, c_rdy_i = 1'b0;
  logic        c_rdy_o, c_vout, c_first, c_last;
  logic [49:0] c_din = '0;
  logic [49:0] c_dout;

  keccak_pi_pipe #(.SLICES_PARALLEL(1), .SHARES(2), .LANE_WIDTH(64)) u_dut_a (
    .ClkxCI(clk), .RstxRBI(rst_n), .ClearxSI(a_clr), .SlicesxDI(a_din),
    .ValidxSI(a_vin), .ReadyxSO(a_rdy_o), .InvxSI(a_inv), .SlicesxDO(a_dout),
    .ValidxSO(a_vout), .ReadyxSI(a_rdy_i), .FirstxSO(a_first), .LastxSO(a_last));

  keccak_pi_pipe #(.SLICES_PARALLEL(4), .SHARES(2), .LANE_WIDTH(64)) u_dut_b (
    .ClkxCI(clk), .RstxRBI(rst_n), .ClearxSI(b_clr), .SlicesxDI(b_din),
    .ValidxSI(b_vin), .ReadyxSO(b_rdy_o), .InvxSI(b_inv), .SlicesxDO(b_dout),
    .ValidxSO(b_vout), .ReadyxSI(b_rdy_i), .FirstxSO(b_first), .LastxSO(b_last));

  keccak_pi_pipe #(.SLICES_PARALLEL(2), .SHARES(1), .LANE_WIDTH(2)) u_dut_c (
    .ClkxCI(clk), .RstxRBI(rst_n), .ClearxSI(c_clr), .SlicesxDI(c_din),
    .ValidxSI(c_vin), .ReadyxSO(c_rdy_o), .InvxSI(c_inv), .SlicesxDO(c_dout),
    .ValidxSO(c_vout), .ReadyxSI(c_rdy_i), .FirstxSO(c_first), .LastxSO(c_last));

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Pi straight from the lane rule: lane (x,y) <-> lane (y,(2x+3y)%5), per share and slice.
  function automatic logic [199:0] model_pi(input logic [199:0] d, input bit inv,
                                            input int sp, input int shares);
    logic [199:0] r;
    int a;
    int b;
    r = '0;
    for (int s = 0; s < shares; s++)
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          for (int z = 0; z < sp; z++) begin
            a = s * 25 * sp + (5 * x + y) * sp + z;
            b = s * 25 * sp + (5 * y + (2 * x + 3 * y) % 5) * sp + z;
            if (inv) r[a] = d[b];
            else     r[b] = d[a];
          end
    return r;
  endfunction

  function automatic logic [199:0] rand200();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom();
    return t[199:0];
  endfunction

  // Scoreboard for B: a FIFO of expected beats tagged with their beat index.
  typedef struct {
    logic [199:0] data;
    int           idx;
  } ent_t;
  ent_t b_q[$];
  int   b_icnt = 0;
  bit   b_mode = 1'b0;

  task automatic b_step(input string tag);
    bit           acc;
    bit           del;
    logic [199:0] exp_d;
    ent_t         e;
    acc   = b_vin && !b_clr && (b_q.size() < 2);
    del   = !b_clr && (b_q.size() > 0) && b_rdy_i;
    exp_d = model_pi(b_din, (b_icnt == 0) ? b_inv : b_mode, 4, 2);
    @(posedge clk);
    #1;
    if (b_clr) begin
      b_q.delete();
      b_icnt = 0;
      b_mode = 1'b0;
    end else begin
      if (del) e = b_q.pop_front();
      if (acc) begin
        e.data = exp_d;
        e.idx  = b_icnt;
        b_q.push_back(e);
        if (b_icnt == 0) b_mode = b_inv;
        b_icnt = (b_icnt + 1) % 16;
      end
    end
    chk1({tag, "_ready"}, b_rdy_o, b_q.size() < 2);
    chk1({tag, "_valid"}, b_vout, b_q.size() > 0);
    if (b_q.size() > 0) begin
      chk({tag, "_data"}, b_dout, b_q[0].data);
      chk1({tag, "_first"}, b_first, b_q[0].idx == 0);
      chk1({tag, "_last"}, b_last, b_q[0].idx == 15);
    end else begin
      chk1({tag, "_first"}, b_first, 1'b0);
      chk1({tag, "_last"}, b_last, 1'b0);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [199:0] t;
    logic [199:0] d0;
    logic [199:0] d1;
    logic [199:0] orig [16];
    logic [199:0] fwd [16];

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_a_ready", a_rdy_o, 1'b1);
    chk1("rst_a_valid", a_vout, 1'b0);
    chk1("rst_a_first", a_first, 1'b0);
    chk1("rst_a_last", a_last, 1'b0);
    chk("rst_a_data", 200'(a_dout), '0);
    chk1("rst_b_ready", b_rdy_o, 1'b1);
    chk1("rst_b_valid", b_vout, 1'b0);
    chk("rst_b_data", b_dout, '0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Single lane (1,0) of share 0 lands on lane (0,2)
    a_din = 50'h20; a_vin = 1'b1; a_inv = 1'b0; a_rdy_i = 1'b1;
    chk1("t1_pre_valid", a_vout, 1'b0);
    cyc();
    a_vin = 1'b0;
    chk1("t1_valid", a_vout, 1'b1);
    chk("t1_data", 200'(a_dout), 200'h4);
    chk1("t1_first", a_first, 1'b1);
    chk1("t1_last", a_last, 1'b0);
    cyc();
    chk1("t1_drained", a_vout, 1'b0);

    // Flush A so the backpressure test starts a fresh state
    a_clr = 1'b1;
    cyc();
    a_clr = 1'b0;
    chk1("a_clr_ready", a_rdy_o, 1'b1);
    chk1("a_clr_valid", a_vout, 1'b0);

    // Backpressure: exactly two beats fit
    t = rand200(); d0 = {150'b0, t[49:0]};
    t = rand200(); d1 = {150'b0, t[49:0]};
    a_rdy_i = 1'b0; a_vin = 1'b1; a_din = d0[49:0];
    cyc();
    chk1("t3_b1_ready", a_rdy_o, 1'b1);
    chk1("t3_b1_first", a_first, 1'b1);
    chk("t3_b1_data", 200'(a_dout), model_pi(d0, 1'b0, 1, 2));
    a_din = d1[49:0];
    cyc();
    chk1("t3_full_ready", a_rdy_o, 1'b0);
    t = rand200();
    a_din = t[49:0];
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk1("t3_stall_ready", a_rdy_o, 1'b0);
      chk1("t3_stall_valid", a_vout, 1'b1);
      chk("t3_stall_data", 200'(a_dout), model_pi(d0, 1'b0, 1, 2));
    end
    a_vin = 1'b0; a_rdy_i = 1'b1;
    chk1("t3_release_ready_same_cycle", a_rdy_o, 1'b0);
    cyc();
    chk1("t3_rel_ready", a_rdy_o, 1'b1);
    chk1("t3_rel_valid", a_vout, 1'b1);
    chk1("t3_rel_first", a_first, 1'b0);
    chk("t3_rel_data", 200'(a_dout), model_pi(d1, 1'b0, 1, 2));
    cyc();
    chk1("t3_empty_valid", a_vout, 1'b0);

    // One beat per state: every beat is first and last and takes the live mode
    c_rdy_i = 1'b1; c_vin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t = rand200();
      c_din = t[49:0];
      c_inv = i[0];
      t = {150'b0, t[49:0]};
      cyc();
      chk1("c_valid", c_vout, 1'b1);
      chk1("c_first", c_first, 1'b1);
      chk1("c_last", c_last, 1'b1);
      chk("c_data", 200'(c_dout), model_pi(t, i[0], 2, 1));
    end
    c_vin = 1'b0;
    cyc();
    chk1("c_idle_first", c_first, 1'b0);
    chk1("c_idle_last", c_last, 1'b0);
    chk1("c_idle_ready", c_rdy_o, 1'b1);

    // Round trip on B: pi then inverse pi restores the data, no bubbles
    b_rdy_i = 1'b1; b_vin = 1'b1;
    for (int k = 0; k < 16; k++) begin
      orig[k] = rand200();
      fwd[k]  = model_pi(orig[k], 1'b0, 4, 2);
      b_din   = orig[k];
      b_inv   = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      b_step("t2_fwd");
    end
    for (int k = 0; k < 16; k++) begin
      b_din = fwd[k];
      b_inv = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      b_step("t2_inv");
      chk("t2_roundtrip", b_dout, orig[k]);
    end

    // Mode toggled every beat is ignored after beat 0; next state re-samples
    for (int k = 0; k < 20; k++) begin
      b_din = rand200();
      b_inv = (k < 16) ? 1'(k % 2 == 0) : 1'(k % 2 == 1);
      b_step("t4");
    end

    // Random traffic with backpressure and occasional flushes
    for (int k = 0; k < 200; k++) begin
      b_din   = rand200();
      b_vin   = ($urandom_range(0, 3) != 0);
      b_rdy_i = ($urandom_range(0, 2) != 0);
      b_inv   = 1'($urandom_range(0, 1));
      b_clr   = ($urandom_range(0, 39) == 0);
      b_step("rnd");
    end
    b_clr = 1'b0;

    // Flush with the buffer full and a beat offered
    b_rdy_i = 1'b0; b_vin = 1'b1; b_inv = 1'b0;
    b_din = rand200(); b_step("t5_fill");
    b_din = rand200(); b_step("t5_fill");
    chk1("t5_full", b_rdy_o, 1'b0);
    b_clr = 1'b1; b_din = rand200();
    b_step("t5_clr");
    chk1("t5_clr_valid", b_vout, 1'b0);
    chk1("t5_clr_ready", b_rdy_o, 1'b1);
    b_clr = 1'b0; b_rdy_i = 1'b1;
    b_inv = 1'b1; b_din = rand200(); b_step("t5_beat0");
    chk1("t5_beat0_first", b_first, 1'b1);
    b_inv = 1'b0; b_din = rand200(); b_step("t5_beat1");

    // Asynchronous reset between edges, mid-state with data buffered
    b_rdy_i = 1'b0; b_vin = 1'b1;
    b_din = rand200(); b_step("t6_pre");
    #3 rst_n = 1'b0;
    #1;
    chk1("t6_rst_valid", b_vout, 1'b0);
    chk1("t6_rst_ready", b_rdy_o, 1'b1);
    chk1("t6_rst_first", b_first, 1'b0);
    chk1("t6_rst_last", b_last, 1'b0);
    chk("t6_rst_data", b_dout, '0);
    b_q.delete();
    b_icnt = 0;
    b_mode = 1'b0;
    #3 rst_n = 1'b1;
    b_rdy_i = 1'b1; b_inv = 1'b1; b_din = rand200();
    b_step("t6_beat0");
    chk1("t6_beat0_first", b_first, 1'b1);
    b_vin = 1'b0;
    b_step("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
